ssd_display_ctrl: RTL and testbench

Parametrised seven-segment display controller for the Nexys A7 board I/O path of the single-cycle RISC-V CPU. It is the successor to the fixed 4-digit hex SSD driver. The block captures a DATA_W-bit value on a load pulse and formats it in hex, unsigned decimal or signed decimal; decimal uses a sequential double-dabble converter. It then time-multiplexes the result across DIGITS anodes, with leading-zero blanking and overflow indication.

---
 rtl/ssd_display_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ssd_display_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_display_ctrl.sv
// Seven-segment display controller: captures a value, formats it as hex or
// (signed) decimal via a sequential double-dabble, and scans it across DIGITS anodes.
module ssd_display_ctrl #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic              blank_lz,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int unsigned NBCD = (DATA_W * 3 + 9) / 10;
  localparam int unsigned NHEX = (DATA_W + 3) / 4;
  localparam int unsigned NSRC = (NBCD > NHEX) ? NBCD : NHEX;
  localparam int unsigned NALL = (NSRC > DIGITS) ? NSRC : DIGITS;
  localparam int unsigned CW   = $clog2(DATA_W + 1);
  localparam int unsigned RW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ABS    = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_FORMAT = 3'd3;

  // Glyph codes held in the display buffer: 0-15 hex digits, then dash and blank.
  localparam logic [4:0] G_DASH  = 5'd16;
  localparam logic [4:0] G_BLANK = 5'd17;

  localparam logic [DIGITS-1:0] AN_OFF  = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;

  logic [2:0]        state_q;
  logic [DATA_W-1:0] val_q;
  logic [DATA_W-1:0] mag_q;
  logic [NBCD*4-1:0] bcd_q;
  logic [NBCD*4-1:0] bcd_adj;
  logic [CW-1:0]     cnt_q;
  logic              dec_q;
  logic              sgn_q;
  logic              lz_q;
  logic              neg_q;
  logic              ovf_q;
  logic              done_q;
  logic [4:0]        buf_q   [DIGITS];
  logic [4:0]        fmt_buf [DIGITS];
  logic              fmt_ovf;
  logic              fit_ovf;
  logic [NALL*4-1:0] src_w;
  int unsigned       ms;
  int unsigned       sign_pos;
  logic [RW-1:0]     ref_q;
  logic [SW-1:0]     scan_q;
  logic [DIGITS-1:0] anode_q;
  logic [6:0]        seg_q;

  function automatic logic [6:0] glyph(input logic [4:0] g);
    logic [6:0] s;
    case (g)
      5'd0:    s = 7'h3F;
      5'd1:    s = 7'h06;
      5'd2:    s = 7'h5B;
      5'd3:    s = 7'h4F;
      5'd4:    s = 7'h66;
      5'd5:    s = 7'h6D;
      5'd6:    s = 7'h7D;
      5'd7:    s = 7'h07;
      5'd8:    s = 7'h7F;
      5'd9:    s = 7'h6F;
      5'd10:   s = 7'h77;
      5'd11:   s = 7'h7C;
      5'd12:   s = 7'h39;
      5'd13:   s = 7'h5E;
      5'd14:   s = 7'h79;
      5'd15:   s = 7'h71;
      G_DASH:  s = 7'h40;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < NBCD; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = 4'(bcd_q[4*k +: 4] + 4'd3);
    end
  end

  // Sign must sit one digit above the most significant digit, so ms+1 must still
  // be a physical digit whether or not leading zeros are blanked.
  always_comb begin
    src_w   = dec_q ? (NALL*4)'(bcd_q) : (NALL*4)'(val_q);
    ms      = 0;
    fit_ovf = 1'b0;
    for (int unsigned k = 0; k < NALL; k++) begin
      if (src_w[4*k +: 4] != 4'd0) begin
        ms = k;
        if (k >= DIGITS) fit_ovf = 1'b1;
      end
    end
    sign_pos = lz_q ? ms + 1 : DIGITS - 1;
    fmt_ovf  = fit_ovf || (neg_q && (ms + 1 >= DIGITS));
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (fmt_ovf)                          fmt_buf[i] = G_DASH;
      else if (neg_q && i == sign_pos)      fmt_buf[i] = G_DASH;
      else if (lz_q && i > ms && i != 0)    fmt_buf[i] = G_BLANK;
      else                                  fmt_buf[i] = {1'b0, src_w[4*i +: 4]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      sgn_q   <= 1'b0;
      lz_q    <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) buf_q[i] <= (i == 0) ? 5'd0 : G_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            val_q   <= value;
            dec_q   <= (mode == 2'b01) || (mode == 2'b10);
            sgn_q   <= (mode == 2'b10);
            lz_q    <= blank_lz;
            neg_q   <= 1'b0;
            state_q <= ((mode == 2'b01) || (mode == 2'b10)) ? ST_ABS : ST_FORMAT;
          end
        end
        ST_ABS: begin
          if (sgn_q && val_q[DATA_W-1]) begin
            neg_q <= 1'b1;
            mag_q <= ~val_q + DATA_W'(1);
          end else begin
            neg_q <= 1'b0;
            mag_q <= val_q;
          end
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {bcd_q, mag_q} <= {bcd_adj[NBCD*4-2:0], mag_q, 1'b0};
          cnt_q          <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_q <= ST_FORMAT;
        end
        ST_FORMAT: begin
          for (int unsigned i = 0; i < DIGITS; i++) buf_q[i] <= fmt_buf[i];
          ovf_q   <= fmt_ovf;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q  <= '0;
      scan_q <= '0;
    end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_q  <= '0;
      scan_q <= (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + SW'(1);
    end else begin
      ref_q  <= ref_q + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode_q <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      anode_q <= SEG_ACTIVE_LOW ? ~(DIGITS'(1) << scan_q) : (DIGITS'(1) << scan_q);
      seg_q   <= SEG_ACTIVE_LOW ? ~glyph(buf_q[scan_q]) : glyph(buf_q[scan_q]);
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Directed bench for ssd_display_ctrl: 8 digits, 32-bit value, 4-cycle dwell, active-low.
module tb_ssd_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] value = '0;
  logic        load = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        blank_lz = 1'b0;
  logic        busy, done, ovf, dp;
  logic [7:0]  anode;
  logic [6:0]  seg;

  int nvec = 0;
  int nerr = 0;
  logic [6:0] shown [7:0];
  bit         cap_ok;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000, GA = 7'b0001000, GB = 7'b0000011, GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001, GM = 7'b0111111, GX = 7'b1111111;

  ssd_display_ctrl #(
    .DIGITS(8),
    .DATA_W(32),
    .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .mode(mode), .blank_lz(blank_lz),
    .busy(busy), .done(done), .ovf(ovf), .anode(anode), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_load(input logic [31:0] v, input logic [1:0] m, input logic lz);
    @(negedge clk);
    value = v; mode = m; blank_lz = lz; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  // Records the segment pattern shown while each anode is active.
  task automatic capture();
    logic [7:0] pat;
    int t;
    cap_ok = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      pat = ~(8'b1 << k);
      t = 0;
      while (anode !== pat && t < 64) begin
        @(negedge clk);
        t++;
      end
      if (t >= 64) cap_ok = 1'b0;
      shown[k] = seg;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b want 0", done); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    nvec++; if (anode !== 8'hFF) begin nerr++; $display("FAIL rst_anode: got %b want 11111111", anode); end
    nvec++; if (seg !== GX) begin nerr++; $display("FAIL rst_seg: got %b want %b", seg, GX); end
    nvec++; if (dp !== 1'b1) begin nerr++; $display("FAIL rst_dp: got %b want 1", dp); end
    rst = 1'b1;
  endtask

  task automatic test_scan();
    logic [7:0] pat;
    int t;
    int d;
    t = 0;
    while (anode !== 8'b11111101 && t < 64) begin @(negedge clk); t++; end
    nvec++; if (t >= 64) begin nerr++; $display("FAIL scan_start: anode=%b never reached 11111101", anode); end
    for (int s = 2; s <= 9; s++) begin
      d = s % 8;
      pat = ~(8'b1 << d);
      t = 0;
      do begin @(negedge clk); t++; end while (anode !== pat && t < 20);
      nvec++; if (t !== 4) begin nerr++; $display("FAIL scan_dwell%0d: cycles=%0d want 4", d, t); end
      nvec++;
      if (seg !== ((d == 0) ? G0 : GX)) begin
        nerr++; $display("FAIL scan_seg%0d: got %b want %b", d, seg, (d == 0) ? G0 : GX);
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] exp [7:0];
    int lat, bc;
    exp = '{GX, GX, GX, GX, GA, GB, GC, GD};
    do_load(32'h0000ABCD, 2'b00, 1'b1);
    wait_done(lat, bc);
    nvec++; if (lat !== 2) begin nerr++; $display("FAIL hex_latency: got %0d want 2", lat); end
    nvec++; if (bc !== 1) begin nerr++; $display("FAIL hex_busy: got %0d cycles want 1", bc); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL hex_ovf: got %b want 0", ovf); end
    capture();
    nvec++; if (!cap_ok) begin nerr++; $display("FAIL hex_capture: scan timeout got 0 want 1"); end
    for (int k = 0; k < 8; k++) begin
      nvec++; if (shown[k] !== exp[k]) begin nerr++; $display("FAIL hex_digit%0d: got %b want %b", k, shown[k], exp[k]); end
    end
  endtask

  task automatic test_udec();
    logic [6:0] exp [7:0];
    int lat, bc, extra;
    exp = '{G1, G2, G3, G4, G5, G6, G7, G8};
    do_load(32'd12345678, 2'b01, 1'b1);
    lat = -1; bc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 10) begin value = 32'd99; mode = 2'b00; load = 1'b1; end
      if (c == 11) load = 1'b0;
      if (busy) bc++;
      if (done) begin lat = c; break; end
    end
    load = 1'b0;
    nvec++; if (lat !== 35) begin nerr++; $display("FAIL udec_latency: got %0d want 35", lat); end
    nvec++; if (bc !== 34) begin nerr++; $display("FAIL udec_busy: got %0d cycles want 34", bc); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL udec_ovf: got %b want 0", ovf); end
    capture();
    nvec++; if (!cap_ok) begin nerr++; $display("FAIL udec_capture: scan timeout got 0 want 1"); end
    for (int k = 0; k < 8; k++) begin
      nvec++; if (shown[k] !== exp[k]) begin nerr++; $display("FAIL udec_digit%0d: got %b want %b", k, shown[k], exp[k]); end
    end
    extra = 0;
    repeat (40) begin @(negedge clk); if (done || busy) extra++; end
    nvec++; if (extra !== 0) begin nerr++; $display("FAIL udec_ignored_load: got %0d busy/done cycles want 0", extra); end
  endtask

  task automatic test_sdec();
    logic [6:0] exp [7:0];
    int lat, bc;
    exp = '{GX, GX, GX, GX, GX, GM, G4, G2};
    do_load(32'hFFFFFFD6, 2'b10, 1'b1);
    wait_done(lat, bc);
    nvec++; if (lat !== 35) begin nerr++; $display("FAIL sdec_latency: got %0d want 35", lat); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL sdec_ovf: got %b want 0", ovf); end
    capture();
    for (int k = 0; k < 8; k++) begin
      nvec++; if (shown[k] !== exp[k]) begin nerr++; $display("FAIL sdec_lz_digit%0d: got %b want %b", k, shown[k], exp[k]); end
    end
    exp = '{GM, G0, G0, G0, G0, G0, G4, G2};
    do_load(32'hFFFFFFD6, 2'b10, 1'b0);
    wait_done(lat, bc);
    nvec++; if (lat !== 35) begin nerr++; $display("FAIL sdec_nolz_latency: got %0d want 35", lat); end
    capture();
    for (int k = 0; k < 8; k++) begin
      nvec++; if (shown[k] !== exp[k]) begin nerr++; $display("FAIL sdec_nolz_digit%0d: got %b want %b", k, shown[k], exp[k]); end
    end
  endtask

  task automatic test_ovf();
    logic [6:0] exp [7:0];
    int lat, bc;
    do_load(32'd100000000, 2'b01, 1'b1);
    wait_done(lat, bc);
    nvec++; if (ovf !== 1'b1) begin nerr++; $display("FAIL ovf_set: got %b want 1", ovf); end
    capture();
    for (int k = 0; k < 8; k++) begin
      nvec++; if (shown[k] !== GM) begin nerr++; $display("FAIL ovf_digit%0d: got %b want %b", k, shown[k], GM); end
    end
    exp = '{GX, GX, GX, GX, GX, GX, GX, G7};
    do_load(32'd7, 2'b01, 1'b1);
    wait_done(lat, bc);
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    capture();
    for (int k = 0; k < 8; k++) begin
      nvec++; if (shown[k] !== exp[k]) begin nerr++; $display("FAIL ovf_clear_digit%0d: got %b want %b", k, shown[k], exp[k]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp [7:0];
    int lat, bc;
    do_load(32'd100000000, 2'b01, 1'b1);
    wait_done(lat, bc);
    nvec++; if (ovf !== 1'b1) begin nerr++; $display("FAIL mid_pre_ovf: got %b want 1", ovf); end
    do_load(32'd12345678, 2'b01, 1'b1);
    repeat (11) @(negedge clk);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_busy: got %b want 0", busy); end
    nvec++; if (anode !== 8'hFF) begin nerr++; $display("FAIL mid_anode: got %b want 11111111", anode); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL mid_ovf: got %b want 0", ovf); end
    nvec++; if (seg !== GX) begin nerr++; $display("FAIL mid_seg: got %b want %b", seg, GX); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp = '{GX, GX, GX, GX, GX, GX, GX, G0};
    capture();
    for (int k = 0; k < 8; k++) begin
      nvec++; if (shown[k] !== exp[k]) begin nerr++; $display("FAIL mid_buf_digit%0d: got %b want %b", k, shown[k], exp[k]); end
    end
    exp = '{G0, G0, G0, G0, G0, G0, G0, G5};
    do_load(32'h5, 2'b00, 1'b0);
    wait_done(lat, bc);
    nvec++; if (lat !== 2) begin nerr++; $display("FAIL mid_next_latency: got %0d want 2", lat); end
    capture();
    for (int k = 0; k < 8; k++) begin
      nvec++; if (shown[k] !== exp[k]) begin nerr++; $display("FAIL mid_next_digit%0d: got %b want %b", k, shown[k], exp[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hex();
    test_udec();
    test_sdec();
    test_ovf();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
